// File: rtl/gate_sweep_checker_if.sv
// Sweep bus between the exhaustive gate checker and its gate/consumer side.
// master = checker, slave = gate under test plus result consumer.
interface gate_sweep_checker_if #(
    parameter int N     = 2,
    parameter int ERR_W = 8
);
    logic             start;
    logic [1:0]       op;
    logic [N-1:0]     stim;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [N-1:0]     first_fail_vec;
    logic             first_fail_valid;

    modport master (
        input  start, op, dut_y,
        output stim, busy, done, pass,
        output err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, op, dut_y,
        input  stim, busy, done, pass,
        input  err_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table checker for N-input reduction gates.
// Define GATE_SWEEP_FIRST_FAIL_EN to build the first-fail capture.
module gate_sweep_checker #(
    parameter int N      = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input logic                 clk,
    input logic                 rst,
    gate_sweep_checker_if.master bus
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [N-1:0]     stim_q, stim_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;

    logic golden;
    logic launch;
    logic sample;
    logic last;
    logic mismatch;

    always_comb begin
        unique case (op_q)
            2'b00:   golden = &stim_q;
            2'b01:   golden = |stim_q;
            2'b10:   golden = ^stim_q;
            default: golden = ~|stim_q;
        endcase
    end

    // DONE also accepts start so back-to-back sweeps lose no cycle
    assign launch   = bus.start && (state_q != S_SWEEP);
    assign sample   = (state_q == S_SWEEP) && (cnt_q == CW'(SETTLE - 1));
    assign last     = &stim_q;
    assign mismatch = sample && (bus.dut_y != golden);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_SWEEP;
            S_SWEEP: if (sample && last) state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_SWEEP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            S_SWEEP: bus.busy = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        op_d   = op_q;
        stim_d = stim_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        pass_d = pass_q;
        if (launch) begin
            op_d   = bus.op;
            stim_d = '0;
            cnt_d  = '0;
            err_d  = '0;
            pass_d = 1'b0;
        end else if (state_q == S_SWEEP) begin
            cnt_d = cnt_q + 1'b1;
            if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
            if (sample) begin
                cnt_d = '0;
                if (last) begin
                    stim_d = '0;
                    pass_d = (err_d == '0);
                end else begin
                    stim_d = stim_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 2'b00;
            stim_q <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            stim_q <= stim_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            pass_q <= pass_d;
        end
    end

    assign bus.stim      = stim_q;
    assign bus.err_count = err_q;
    assign bus.pass      = pass_q;

`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic [N-1:0] ffv_q, ffv_d;
    logic         ffok_q, ffok_d;

    always_comb begin
        ffv_d  = ffv_q;
        ffok_d = ffok_q;
        if (launch) begin
            ffok_d = 1'b0;
        end else if (mismatch && !ffok_q) begin
            ffv_d  = stim_q;
            ffok_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ffv_q  <= '0;
            ffok_q <= 1'b0;
        end else begin
            ffv_q  <= ffv_d;
            ffok_q <= ffok_d;
        end
    end

    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffok_q;
`else
    assign bus.first_fail_vec   = '0;
    assign bus.first_fail_valid = 1'b0;
`endif

endmodule
